// File: rtl/stim_pattern_gen.sv
// stim_pattern_gen: clocked stimulus source for DUT benches and on-board self-test.
// Sweeps N_CH channels through binary, Gray, walking-one or walking-zero patterns.
// Each pattern is held for HOLD cycles. Supports single or continuous sweeps,
// abort via stop, and a one-cycle done pulse. Every output is driven from a flop.
module stim_pattern_gen #(
    parameter int N_CH   = 2,
    parameter int HOLD   = 100,
    parameter int HOLD_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic [1:0]      mode,
    input  logic            continuous,
    output logic [N_CH-1:0] pattern_out,
    output logic            step,
    output logic            busy,
    output logic            done,
    output logic [7:0]      sweep_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Last hold count before an advance, and last index of each sequence family.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [N_CH:0]     IDX_LAST_COUNT = (N_CH + 1)'((2 ** N_CH) - 1);
    localparam logic [N_CH:0]     IDX_LAST_WALK  = (N_CH + 1)'(N_CH - 1);

    // Pattern for index i under sequence mode m.
    function automatic logic [N_CH-1:0] pat_f(input logic [1:0] m, input logic [N_CH:0] i);
        logic [N_CH-1:0] low_v;
        logic [N_CH-1:0] one_v;
        logic [N_CH-1:0] res_v;
        low_v = i[N_CH-1:0];
        one_v = N_CH'(1'b1) << i;
        case (m)
            2'b00:   res_v = low_v;
            2'b01:   res_v = low_v ^ (low_v >> 1);
            2'b10:   res_v = one_v;
            2'b11:   res_v = ~one_v;
            default: res_v = {N_CH{1'b0}};
        endcase
        return res_v;
    endfunction

    state_t            state_r, state_s;
    logic [HOLD_W-1:0] hold_r, hold_s;
    logic [N_CH:0]     idx_r, idx_s;
    logic [1:0]        mode_r, mode_s;
    logic              cont_r, cont_s;
    logic [N_CH-1:0]   pattern_r, pattern_s;
    logic              step_r, step_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [7:0]        sweep_r, sweep_s;
    logic              last_s;

    assign pattern_out = pattern_r;
    assign step        = step_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign sweep_cnt   = sweep_r;

    // State register and all output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            hold_r    <= {HOLD_W{1'b0}};
            idx_r     <= {(N_CH + 1){1'b0}};
            mode_r    <= 2'b00;
            cont_r    <= 1'b0;
            pattern_r <= {N_CH{1'b0}};
            step_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            sweep_r   <= 8'd0;
        end else begin
            state_r   <= state_s;
            hold_r    <= hold_s;
            idx_r     <= idx_s;
            mode_r    <= mode_s;
            cont_r    <= cont_s;
            pattern_r <= pattern_s;
            step_r    <= step_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            sweep_r   <= sweep_s;
        end
    end

    // Next-state and next-output logic; stop outranks start and any advance.
    always_comb begin
        state_s   = state_r;
        hold_s    = hold_r;
        idx_s     = idx_r;
        mode_s    = mode_r;
        cont_s    = cont_r;
        pattern_s = pattern_r;
        step_s    = 1'b0;
        busy_s    = busy_r;
        done_s    = 1'b0;
        sweep_s   = sweep_r;
        last_s    = mode_r[1] ? (idx_r == IDX_LAST_WALK) : (idx_r == IDX_LAST_COUNT);

        case (state_r)
            ST_IDLE: begin
                pattern_s = {N_CH{1'b0}};
                busy_s    = 1'b0;
                hold_s    = {HOLD_W{1'b0}};
                idx_s     = {(N_CH + 1){1'b0}};
                if (start && !stop) begin
                    state_s   = ST_RUN;
                    mode_s    = mode;
                    cont_s    = continuous;
                    pattern_s = pat_f(mode, {(N_CH + 1){1'b0}});
                    step_s    = 1'b1;
                    busy_s    = 1'b1;
                    sweep_s   = 8'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_s   = ST_IDLE;
                    pattern_s = {N_CH{1'b0}};
                    busy_s    = 1'b0;
                    hold_s    = {HOLD_W{1'b0}};
                    idx_s     = {(N_CH + 1){1'b0}};
                end else if (hold_r == HOLD_LAST) begin
                    hold_s = {HOLD_W{1'b0}};
                    if (!last_s) begin
                        idx_s     = idx_r + {{N_CH{1'b0}}, 1'b1};
                        pattern_s = pat_f(mode_r, idx_r + {{N_CH{1'b0}}, 1'b1});
                        step_s    = 1'b1;
                    end else if (cont_r) begin
                        idx_s     = {(N_CH + 1){1'b0}};
                        pattern_s = pat_f(mode_r, {(N_CH + 1){1'b0}});
                        step_s    = 1'b1;
                        sweep_s   = (sweep_r == 8'd255) ? sweep_r : (sweep_r + 8'd1);
                    end else begin
                        state_s   = ST_DONE;
                        idx_s     = {(N_CH + 1){1'b0}};
                        pattern_s = {N_CH{1'b0}};
                        busy_s    = 1'b0;
                        done_s    = 1'b1;
                    end
                end else begin
                    hold_s = hold_r + {{(HOLD_W - 1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_s   = ST_IDLE;
                pattern_s = {N_CH{1'b0}};
                busy_s    = 1'b0;
            end
            default: begin
                state_s   = ST_IDLE;
                hold_s    = {HOLD_W{1'b0}};
                idx_s     = {(N_CH + 1){1'b0}};
                pattern_s = {N_CH{1'b0}};
                busy_s    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Scoreboard bench for stim_pattern_gen: each sweep request pushes its expected
// step/done events (cycle, pattern, sweep count) derived from the sequence rules;
// a monitor pops and compares whenever the DUT pulses step or done, and checks
// that the held pattern is stable while busy and zero otherwise.
module tb_stim_pattern_gen;

    localparam int N    = 3;
    localparam int HOLD = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         continuous = 1'b0;
    logic [N-1:0] pattern_out;
    logic         step;
    logic         busy;
    logic         done;
    logic [7:0]   sweep_cnt;

    typedef struct {
        int cyc;
        bit is_done;
        int pat;
        int sw;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;

    stim_pattern_gen #(.N_CH(N), .HOLD(HOLD), .HOLD_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .continuous(continuous), .pattern_out(pattern_out), .step(step),
        .busy(busy), .done(done), .sweep_cnt(sweep_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int expv);
        total = total + 1;
        if (act != expv) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic int pat_of(input int m, input int i);
        case (m)
            0:       return i;
            1:       return i ^ (i >> 1);
            2:       return 1 << i;
            default: return ((1 << N) - 1) - (1 << i);
        endcase
    endfunction

    // Monitor: compares events against the scoreboard queue.
    initial begin
        ev_t e;
        int  cur_pat;
        cur_pat = 0;
        forever begin
            @(negedge clk);
            if (step || done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("event_done", int'(done), e.is_done ? 1 : 0);
                    chk("event_step", int'(step), e.is_done ? 0 : 1);
                    chk("event_pattern", int'(pattern_out), e.pat);
                    chk("event_sweep", int'(sweep_cnt), e.sw);
                    chk("event_busy", int'(busy), e.is_done ? 0 : 1);
                    cur_pat = e.pat;
                end
            end else if (busy) begin
                chk("hold_pattern", int'(pattern_out), cur_pat);
            end else begin
                chk("idle_pattern", int'(pattern_out), 0);
            end
        end
    end

    // One sweep request: s = stop cycle (0 = none), rst_at = async reset cycle (0 = none).
    task automatic run(input int m, input int c, input int s, input int rst_at);
        int L, len, k, sw;
        ev_t e;
        L   = (m < 2) ? (1 << N) : N;
        len = (s > 0) ? s : L * HOLD;
        @(negedge clk);
        k          = cyc;
        start      = 1'b1;
        stop       = 1'b0;
        mode       = 2'(m);
        continuous = 1'(c);
        for (int t = 1; t <= len; t++) begin
            if ((t - 1) % HOLD == 0) begin
                sw = (c != 0) ? ((t - 1) / (L * HOLD)) : 0;
                if (sw > 255) sw = 255;
                e.cyc = k + t; e.is_done = 1'b0;
                e.pat = pat_of(m, ((t - 1) / HOLD) % L); e.sw = sw;
                exp_q.push_back(e);
            end
        end
        if (s == 0) begin
            e.cyc = k + len + 1; e.is_done = 1'b1; e.pat = 0; e.sw = 0;
            exp_q.push_back(e);
        end
        for (int t = 1; t <= len + ((s == 0) ? 1 : 0); t++) begin
            @(negedge clk);
            start      = 1'($urandom);
            mode       = 2'($urandom);
            continuous = 1'($urandom);
            stop       = (t == s);
            if (t == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_pattern", int'(pattern_out), 0);
                chk("rst_step", int'(step), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_sweep", int'(sweep_cnt), 0);
                exp_q.delete();
                start = 1'b0;
                stop  = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                repeat (2) @(negedge clk);
                return;
            end
        end
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, c, L, s;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_pattern", int'(pattern_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_step", int'(step), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_sweep", int'(sweep_cnt), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(0, 0, 0, 0);
        run(1, 0, 0, 0);
        run(2, 0, 0, 0);
        run(3, 0, 0, 0);
        run(1, 1, 5 * 8 * HOLD + 2, 0);
        run(0, 0, 8, 0);
        run(0, 0, 8 * HOLD, 0);

        // start and stop together in IDLE: stop wins
        @(negedge clk);
        start = 1'b1; stop = 1'b1; mode = 2'b01;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("start_stop_busy", int'(busy), 0);
        chk("start_stop_step", int'(step), 0);
        @(negedge clk);
        chk("start_stop_idle", int'(busy), 0);

        run(0, 1, 100, 40);
        run(0, 0, 0, 0);
        run(2, 1, 300 * N * HOLD + 4, 0);

        for (int r = 0; r < 12; r++) begin
            m = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 1));
            L = (m < 2) ? (1 << N) : N;
            if (c != 0) s = int'($urandom_range(1, 3 * L * HOLD));
            else if ($urandom_range(0, 1) == 0) s = 0;
            else s = int'($urandom_range(1, L * HOLD));
            run(m, c, s, 0);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
